// File: rtl/btn_input_conditioner.sv
// btn_input_conditioner
//   Turns raw, bouncing board buttons into clean synchronous levels and
//   one-cycle press pulses. Each accepted press is also queued as a button
//   index in a small FIFO that the game logic drains with a valid/ack
//   handshake.
//
// Ports:
//   clk          board clock
//   rst          asynchronous, active-high reset
//   i_btn        raw button pins, asynchronous ([0]=up [1]=right [2]=down
//                [3]=left [4]=game-reset)
//   o_level      debounced button levels
//   o_press      one-cycle pulse on each debounced rising edge
//   o_evt_valid  event FIFO is non-empty
//   o_evt_code   button index at the FIFO head
//   i_evt_ack    pops the head when o_evt_valid is high
//   o_overflow   sticky flag: at least one press event was dropped
//   i_clr_ovf    clears o_overflow
module btn_input_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic             o_evt_valid,
  output logic [2:0]       o_evt_code,
  input  logic             i_evt_ack,
  output logic             o_overflow,
  input  logic             i_clr_ovf
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};

  // Index of the lowest set bit; lower buttons win when several rise together.
  function automatic logic [2:0] lowest_idx(input logic [N_BTN-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [CNT_W-1:0] cnt_r [N_BTN];
  logic [N_BTN-1:0] settle_s;
  logic [N_BTN-1:0] rise_s;

  logic [2:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] count_r;
  logic             push_req_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             multi_s;
  logic             drop_s;

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= {N_BTN{1'b0}};
      sync2_r <= {N_BTN{1'b0}};
    end else begin
      sync1_r <= i_btn;
      sync2_r <= sync1_r;
    end
  end

  // A bit settles when it has differed from the accepted level long enough.
  // rise_s is the cycle-early copy of o_press, so the event enters the FIFO
  // on the same edge that the level and the pulse appear.
  always_comb begin
    settle_s = {N_BTN{1'b0}};
    for (int i = 0; i < N_BTN; i++) begin
      if ((sync2_r[i] != o_level[i]) && (cnt_r[i] == CNT_MAX)) begin
        settle_s[i] = 1'b1;
      end else begin
        settle_s[i] = 1'b0;
      end
    end
    rise_s = settle_s & sync2_r;
  end

  // Per-bit debounce counters, accepted levels and press pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_level <= {N_BTN{1'b0}};
      o_press <= {N_BTN{1'b0}};
      for (int i = 0; i < N_BTN; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      o_press <= rise_s;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2_r[i] == o_level[i]) begin
          // Matching the accepted level (including a glitch back) restarts.
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_MAX) begin
          o_level[i] <= sync2_r[i];
          cnt_r[i]   <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // FIFO control: a pop in the same cycle frees the slot a full push needs.
  always_comb begin
    full_s     = (count_r == OCC_FULL);
    pop_s      = (count_r != OCC_ZERO) && i_evt_ack;
    push_req_s = |rise_s;
    push_s     = push_req_s && (!full_s || pop_s);
    // More than one bit rising at once: only the lowest is kept.
    multi_s    = |(rise_s & (rise_s - N_BTN'(1)));
    drop_s     = multi_s || (push_req_s && !push_s);
  end

  // Head presentation; a stale slot is never shown while empty.
  always_comb begin
    o_evt_valid = (count_r != OCC_ZERO);
    if (o_evt_valid) begin
      o_evt_code = mem_r[rd_ptr_r];
    end else begin
      o_evt_code = 3'd0;
    end
  end

  // Event storage, pointers (wrap naturally at the power-of-two depth) and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= OCC_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 3'd0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= lowest_idx(rise_s);
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + OCC_W'(1);
        2'b01:   count_r <= count_r - OCC_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_overflow <= 1'b0;
    end else if (drop_s) begin
      o_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      o_overflow <= 1'b0;
    end else begin
      o_overflow <= o_overflow;
    end
  end

endmodule

// File: tb/tb_btn_input_conditioner.sv
module tb_btn_input_conditioner;

  localparam int N     = 5;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic         ack = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] o_level;
  logic [N-1:0] o_press;
  logic         o_evt_valid;
  logic [2:0]   o_evt_code;
  logic         o_overflow;

  int n_pass  = 0;
  int n_total = 0;

  btn_input_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(3), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(btn),
    .o_level(o_level), .o_press(o_press),
    .o_evt_valid(o_evt_valid), .o_evt_code(o_evt_code),
    .i_evt_ack(ack), .o_overflow(o_overflow), .i_clr_ovf(clr)
  );

  always #5 clk = ~clk;

  // Reference model: levels follow "D consecutive sampled raw values opposite
  // to the level, all after the last accepted change", with the synchronizer
  // seen as a two-edge delay of the raw pin.
  logic [N-1:0] samp [$];
  int           e = 0;
  int           last_upd [N];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_press = '0;
  bit           m_ovf = 1'b0;
  int           occ = 0;
  int           exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  function automatic bit raw_at(int j, int i);
    if (j < 1 || j > samp.size()) return 1'b0;
    return samp[j-1][i];
  endfunction

  task automatic model_reset();
    e = 0;
    samp.delete();
    for (int i = 0; i < N; i++) last_upd[i] = 0;
    m_level = '0;
    m_press = '0;
    m_ovf   = 1'b0;
    occ     = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic [N-1:0] nl;
    int  rises [$];
    bit  popping;
    bit  drop;
    e++;
    samp.push_back(btn);
    nl      = m_level;
    m_press = '0;
    for (int i = 0; i < N; i++) begin
      bit v;
      bit ok;
      v  = !m_level[i];
      ok = (e - D >= last_upd[i]);
      for (int j = e - D - 1; j <= e - 2; j++) if (raw_at(j, i) != v) ok = 1'b0;
      if (ok) begin
        nl[i]       = v;
        last_upd[i] = e;
        if (v) begin
          m_press[i] = 1'b1;
          rises.push_back(i);
        end
      end
    end
    m_level = nl;
    popping = (occ > 0) && ack;
    drop    = 1'b0;
    if (rises.size() > 0) begin
      if (rises.size() > 1) drop = 1'b1;
      if (occ < DEPTH || popping) begin
        exp_q.push_back(rises[0]);
        occ++;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (popping) occ--;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (!rst) model_edge();
      #1;
    end
  endtask

  // Monitor: compares every cycle; consumes expected codes on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      chk("level", 32'(o_level), 32'(m_level));
      chk("press", 32'(o_press), 32'(m_press));
      chk("evt_valid", 32'(o_evt_valid), 32'(occ != 0));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      if (o_evt_valid) begin
        if (exp_q.size() == 0) begin
          chk("evt_unexpected", 32'(o_evt_valid), 32'd0);
        end else if (ack) begin
          chk("evt_code_pop", 32'(o_evt_code), 32'(exp_q.pop_front()));
        end else begin
          chk("evt_code_head", 32'(o_evt_code), 32'(exp_q[0]));
        end
      end
    end
  end

  task automatic press(input logic [N-1:0] b);
    btn = b;
    step(D + 3);
    btn = '0;
    step(D + 3);
  endtask

  initial begin
    model_reset();
    step(3);
    rst = 1'b0;

    // Single press and release.
    press(5'b00001);
    ack = 1'b1; step(2); ack = 1'b0;

    // Bouncing input never settles.
    for (int k = 0; k < 10; k++) begin
      btn[2] = ~btn[2];
      step(2);
    end
    btn = '0;
    step(8);

    // Queue three presses, drain in order, extra ack while empty.
    press(5'b00001);
    press(5'b00010);
    press(5'b00100);
    ack = 1'b1; step(5); ack = 1'b0;

    // Overflow on fifth press, drain, clear.
    press(5'b00001);
    press(5'b00010);
    press(5'b00100);
    press(5'b01000);
    press(5'b00001);
    ack = 1'b1; step(5); ack = 1'b0;
    clr = 1'b1; step(1); clr = 1'b0;

    // Push when full with a simultaneous pop is accepted.
    press(5'b00001);
    press(5'b00010);
    press(5'b00100);
    press(5'b01000);
    btn = 5'b10000;
    step(D + 1);
    ack = 1'b1; step(1); ack = 1'b0;
    btn = '0;
    step(D + 3);
    ack = 1'b1; step(6); ack = 1'b0;

    // Two buttons rising together.
    press(5'b01010);
    ack = 1'b1; step(2); ack = 1'b0;
    clr = 1'b1; step(1); clr = 1'b0;

    // Reset in the middle of a debounce count.
    btn = 5'b00001;
    step(4);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_press", 32'(o_press), 32'd0);
    chk("rst_valid", 32'(o_evt_valid), 32'd0);
    chk("rst_code", 32'(o_evt_code), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    step(2);
    rst = 1'b0;
    step(D + 3);
    btn = '0;
    step(D + 3);
    ack = 1'b1; step(2); ack = 1'b0;

    // Randomized phase.
    for (int k = 0; k < 40; k++) begin
      btn = N'($urandom_range(0, 31));
      ack = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step($urandom_range(1, 10));
    end
    btn = '0;
    clr = 1'b0;
    ack = 1'b0;
    step(D + 3);
    ack = 1'b1; step(DEPTH + 2); ack = 1'b0;
    @(negedge clk);
    #1;
    chk("final_valid", 32'(o_evt_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/btn_input_conditioner.md
Name: btn_input_conditioner

Overview:
- Input-side counterpart to the game's display path. Converts the raw, asynchronous, bouncing board buttons (up, right, down, left, game-reset) into clean synchronous levels and one-cycle press pulses.
- Queues press events in a small FIFO that the game logic drains with a valid/ack handshake.
- Sits between the board button pins and the game/VGA controller in the top level, clocked by the board clock.

Parameters:
- N_BTN, 5, number of buttons. Bit order: [0]=up, [1]=right, [2]=down, [3]=left, [4]=game-reset.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (5 ms at 100 MHz).
- CNT_W, 19, debounce counter width; must hold DEBOUNCE_CYCLES-1.
- FIFO_DEPTH, 4, event queue entries; power of two.

Ports:
- clk  in  1  board clock
- rst  in  1  reset, asynchronous, active-high
- i_btn  in  N_BTN  raw button pins, asynchronous
- o_level  out  N_BTN  debounced button levels
- o_press  out  N_BTN  one-cycle pulse per button on debounced rising edge
- o_evt_valid  out  1  FIFO non-empty
- o_evt_code  out  3  button index at FIFO head
- i_evt_ack  in  1  consumer pops head when o_evt_valid && i_evt_ack
- o_overflow  out  1  sticky: a press event was dropped
- i_clr_ovf  in  1  clears o_overflow

Behaviour:
- Reset (async assert, sync release): sync flops, counters, o_level, o_press, FIFO pointers and count, o_overflow all 0. Outputs: o_evt_valid=0, o_evt_code=0.
- Synchronizer: 2 flops per bit (sync1, sync2). Only sync2 is used downstream.
- Debounce, per bit, at each edge:
  - If sync2 == o_level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: o_level <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch back to the old level restarts the count.
- Latency: raw change set up before edge 1 and held stable → o_level changes at edge DEBOUNCE_CYCLES+2.
- o_press[i]: registered. High exactly in the first cycle o_level[i] is 1 after a 0→1 update. Releases produce no pulse and no event.
- Event enqueue:
  - Any o_press bit high → push the index of the lowest set bit.
  - Other bits set in the same cycle are dropped and set o_overflow.
- FIFO: o_evt_valid = (count != 0). o_evt_code = head entry, registered/stable while valid and not popped.
  - Pop when o_evt_valid && i_evt_ack.
  - Ack while empty: ignored.
  - Push when full with no pop: event dropped, o_overflow <= 1.
  - Push and pop in the same cycle: both occur, count unchanged, including when full.
  - Pointers wrap modulo FIFO_DEPTH.
- o_overflow: set has priority over i_clr_ovf in the same cycle. Otherwise i_clr_ovf clears it on the next edge.
- Reset mid-operation: discards counters, levels and queued events. A button still held after release needs the full DEBOUNCE_CYCLES+2 again, then produces a press.

Test Plan:
1. DEBOUNCE_CYCLES=4. Raise i_btn[0] before edge 1 and hold → o_level[0] rises at edge 6. o_press[0] is high only in cycle 6. At edge 6, o_evt_valid=1 and o_evt_code=0. Releasing gives o_level[0]=0 at +6 edges and no new event.
2. Toggle i_btn[2] every 2 cycles for 20 cycles, then hold 0 → o_level, o_press and o_evt_valid stay 0 throughout.
3. Press up, right, down in sequence with i_evt_ack=0 → count reaches 3, head code 0. Then ack for 3 cycles → codes 0,1,2 seen in order, then o_evt_valid=0. Extra ack while empty changes nothing.
4. Five sequential presses (codes 0,1,2,3,0) with no ack → fifth dropped, o_overflow=1. Draining yields 0,1,2,3. Pulse i_clr_ovf → o_overflow=0. Push-when-full with simultaneous ack is accepted, o_overflow stays 0.
5. Raise bits 1 and 3 in the same cycle → one event, code 1. o_overflow=1. Both o_press bits pulse.
6. Hold i_btn[0], assert rst when cnt=2, release rst → all outputs 0 immediately on assert. o_level[0] rises 6 edges after release, with one event.
